// File: rtl/fp32pe_feeder_pkg.sv
// Shared vector-ALU package for the FP32 PE feeder.
// Holds the default lane count, the FP32 +0.0 pattern, the beat counter width
// and the feeder FSM state encoding.
package fp32pe_feeder_pkg;

    localparam int unsigned VALU_LANES = 8;
    localparam logic [31:0] FP32_ZERO  = 32'h0000_0000;
    localparam int unsigned BEAT_W     = 14;

    // FSM state encoding, kept as plain constants for legacy tools.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CLEAR  = 3'd1;
    localparam logic [2:0] ST_STREAM = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

endpackage

// File: rtl/fp32_lane_mask.sv
// Combinational lane mask: lanes with index >= live are replaced by FP32 +0.0,
// lanes below live pass through bit-exact.
// Ports:
//   data   - packed FP32 lanes in, lane k at [32k+31:32k]
//   live   - number of live lanes, counted from lane 0
//   masked - data with the dead lanes zeroed
module fp32_lane_mask
    import fp32pe_feeder_pkg::*;
#(
    parameter int unsigned LANES  = VALU_LANES,
    parameter int unsigned LIVE_W = $clog2(LANES + 1)
) (
    input  logic [32*LANES-1:0] data,
    input  logic [LIVE_W-1:0]   live,
    output logic [32*LANES-1:0] masked
);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign masked[32*k +: 32] = (live > LIVE_W'(k)) ? data[32*k +: 32] : FP32_ZERO;
    end

endmodule

// File: rtl/fp32pe_feeder.sv
// Operand feeder for an external FP32 dot-product PE.
// A job clears the PE accumulator, streams ceil(len/LANES) operand beats
// (zeroing dead lanes of a partial final beat and idle stall cycles), then
// drives zeros while the PE pipeline drains and pulses done.
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   start, len         - job request and length in elements (sampled in IDLE)
//   in_valid/in_ready  - operand beat handshake
//   in_a, in_b         - packed FP32 operand lanes
//   pe_a, pe_b, pe_clr - registered lanes and accumulator clear to the PE
//   busy, done         - job in progress, one-cycle completion pulse
module fp32pe_feeder
    import fp32pe_feeder_pkg::*;
#(
    parameter int unsigned LANES     = VALU_LANES,
    parameter int unsigned CLR_CYC   = 2,
    parameter int unsigned DRAIN_CYC = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [15:0]         len,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [32*LANES-1:0] in_a,
    input  logic [32*LANES-1:0] in_b,
    output logic [32*LANES-1:0] pe_a,
    output logic [32*LANES-1:0] pe_b,
    output logic                pe_clr,
    output logic                busy,
    output logic                done
);

    localparam int unsigned LIVE_W     = $clog2(LANES + 1);
    localparam logic [15:0] CLR_LAST   = 16'(CLR_CYC - 1);
    localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_CYC - 1);
    localparam logic [32*LANES-1:0] LANES_ZERO = {LANES{FP32_ZERO}};

    logic [2:0]          state_q, state_d;
    logic [BEAT_W-1:0]   beats_q, beats_d;
    logic [LIVE_W-1:0]   rem_q, rem_d;
    logic [15:0]         cyc_q, cyc_d;
    logic [32*LANES-1:0] pe_a_q, pe_a_d, pe_b_q, pe_b_d;
    logic                pe_clr_q, pe_clr_d;
    logic [LIVE_W-1:0]   live;
    logic [32*LANES-1:0] masked_a, masked_b;
    logic                accept;

    assign in_ready = (state_q == ST_STREAM);
    assign accept   = in_ready & in_valid;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign pe_a     = pe_a_q;
    assign pe_b     = pe_b_q;
    assign pe_clr   = pe_clr_q;

    // Only the last beat of a job whose length is not a lane multiple is partial.
    assign live = (beats_q == BEAT_W'(1) && rem_q != '0) ? rem_q : LIVE_W'(LANES);

    fp32_lane_mask #(
        .LANES  (LANES),
        .LIVE_W (LIVE_W)
    ) u_mask_a (
        .data   (in_a),
        .live   (live),
        .masked (masked_a)
    );

    fp32_lane_mask #(
        .LANES  (LANES),
        .LIVE_W (LIVE_W)
    ) u_mask_b (
        .data   (in_b),
        .live   (live),
        .masked (masked_b)
    );

    always_comb begin
        state_d = state_q;
        beats_d = beats_q;
        rem_d   = rem_q;
        cyc_d   = cyc_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CLEAR;
                    beats_d = BEAT_W'((32'(len) + LANES - 1) / LANES);
                    rem_d   = LIVE_W'(32'(len) % LANES);
                    cyc_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (cyc_q == CLR_LAST) begin
                    cyc_d   = '0;
                    // A zero-length job has no beats: go straight to draining.
                    state_d = (beats_q != '0) ? ST_STREAM : ST_DRAIN;
                end else begin
                    cyc_d = cyc_q + 16'd1;
                end
            end
            ST_STREAM: begin
                if (in_valid) begin
                    beats_d = beats_q - BEAT_W'(1);
                    if (beats_q == BEAT_W'(1)) begin
                        state_d = ST_DRAIN;
                        cyc_d   = '0;
                    end
                end
            end
            ST_DRAIN: begin
                if (cyc_q == DRAIN_LAST) begin
                    cyc_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cyc_d = cyc_q + 16'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The PE accumulates every cycle, so anything but an accepted beat feeds zeros.
    always_comb begin
        pe_a_d   = accept ? masked_a : LANES_ZERO;
        pe_b_d   = accept ? masked_b : LANES_ZERO;
        pe_clr_d = (state_d == ST_CLEAR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            beats_q  <= '0;
            rem_q    <= '0;
            cyc_q    <= '0;
            pe_a_q   <= LANES_ZERO;
            pe_b_q   <= LANES_ZERO;
            // Hold the PE in clear until the first edge after reset release.
            pe_clr_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            beats_q  <= beats_d;
            rem_q    <= rem_d;
            cyc_q    <= cyc_d;
            pe_a_q   <= pe_a_d;
            pe_b_q   <= pe_b_d;
            pe_clr_q <= pe_clr_d;
        end
    end

endmodule

// File: tb/tb_fp32pe_feeder.sv
// Self-checking bench for fp32pe_feeder: a timestamp-based job model predicts
// every output on every cycle; directed jobs pin latencies and lane masking.
module tb_fp32pe_feeder;

    localparam int LANES = 8;
    localparam int CLR   = 2;
    localparam int DRAIN = 24;
    localparam int W     = 32 * LANES;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [15:0]  len = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic [W-1:0] pe_a;
    logic [W-1:0] pe_b;
    logic         pe_clr;
    logic         busy;
    logic         done;

    fp32pe_feeder #(
        .LANES     (LANES),
        .CLR_CYC   (CLR),
        .DRAIN_CYC (DRAIN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .pe_a     (pe_a),
        .pe_b     (pe_b),
        .pe_clr   (pe_clr),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    // Job model: a job is described by its start cycle, beat count and
    // accepted-beat count; the done cycle follows from the last acceptance.
    bit           m_active = 1'b0;
    bit           m_hold = 1'b1;
    int           m_ts = 0;
    int           m_nb = 0;
    int           m_rem = 0;
    int           m_acc = 0;
    int           m_done_cyc = -1;
    logic [W-1:0] m_next_a = '0;
    logic [W-1:0] m_next_b = '0;

    int           done_count = 0;
    int           last_done_cyc = -1;
    int           fin_cyc = -1;
    logic [W-1:0] fin_in_a = '0;
    logic [W-1:0] fin_pe_a = '0;

    bit e_busy, e_rdy, e_done, e_clr;
    int live;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %h want %h", name, cyc, act, exp);
    endtask

    function automatic logic [W-1:0] mask(input logic [W-1:0] d, input int nlive);
        logic [W-1:0] r;
        r = d;
        for (int k = nlive; k < LANES; k++) r[32*k +: 32] = 32'h0;
        return r;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Compare process: check outputs for this cycle, then advance the model
    // across the coming edge.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            e_busy = 1'b0;
            e_rdy  = 1'b0;
            e_done = 1'b0;
            e_clr  = 1'b1;
        end else begin
            e_busy = m_active;
            e_clr  = m_hold || (m_active && cyc >= m_ts + 1 && cyc <= m_ts + CLR);
            e_rdy  = m_active && cyc >= m_ts + CLR + 1 && m_acc < m_nb;
            e_done = m_active && cyc == m_done_cyc;
        end
        chk("busy", W'(busy), W'(e_busy));
        chk("in_ready", W'(in_ready), W'(e_rdy));
        chk("done", W'(done), W'(e_done));
        chk("pe_clr", W'(pe_clr), W'(e_clr));
        chk("pe_a", pe_a, rst ? '0 : m_next_a);
        chk("pe_b", pe_b, rst ? '0 : m_next_b);
        if (done) begin
            done_count++;
            last_done_cyc = cyc;
        end
        if (cyc == fin_cyc) fin_pe_a = pe_a;

        if (rst) begin
            m_active = 1'b0;
            m_hold   = 1'b1;
            m_next_a = '0;
            m_next_b = '0;
        end else begin
            m_hold = 1'b0;
            if (e_rdy && in_valid) begin
                live = (m_acc == m_nb - 1 && m_rem != 0) ? m_rem : LANES;
                m_next_a = mask(in_a, live);
                m_next_b = mask(in_b, live);
                m_acc++;
                if (m_acc == m_nb) begin
                    m_done_cyc = cyc + 1 + DRAIN;
                    fin_in_a   = in_a;
                    fin_cyc    = cyc + 1;
                end
            end else begin
                m_next_a = '0;
                m_next_b = '0;
            end
            if (!m_active && start) begin
                m_active   = 1'b1;
                m_ts       = cyc;
                m_nb       = (int'(len) + LANES - 1) / LANES;
                m_rem      = int'(len) % LANES;
                m_acc      = 0;
                m_done_cyc = (m_nb == 0) ? cyc + 1 + CLR + DRAIN : -1;
            end else if (e_done) begin
                m_active = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        for (int k = 0; k < LANES; k++) begin
            in_a[32*k +: 32] = $urandom;
            in_b[32*k +: 32] = $urandom;
        end
    endtask

    // Runs one job; returns start-to-done latency (-1 on timeout) and done count.
    task automatic run_job(input int l, input int stall_from, input int stall_n,
                           input int valid_pct, input int restart_at,
                           output int lat, output int ndone);
        int s, d0, k, rel;
        d0 = done_count;
        len = 16'(l);
        start = 1'b1;
        in_valid = 1'b0;
        rand_data();
        s = cyc;
        tick();
        k = 0;
        while (done_count == d0 && k < 20000) begin
            rel = cyc - s;
            start = (rel == restart_at);
            len = (rel == restart_at) ? 16'd5 : 16'(l);
            in_valid = (rel >= stall_from && rel < stall_from + stall_n) ? 1'b0 :
                       ($urandom_range(99) < valid_pct);
            rand_data();
            tick();
            k++;
        end
        start = 1'b0;
        in_valid = 1'b0;
        if (done_count == d0) begin
            chk("job_timeout", W'(0), W'(1));
            lat = -1;
        end else begin
            lat = last_done_cyc - s;
        end
        repeat (3) tick();
        ndone = done_count - d0;
    endtask

    int lat, nd, s0;

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Two back-to-back full beats.
        run_job(16, 0, 0, 100, -1, lat, nd);
        chk("lat_len16", W'(lat), W'(29));
        chk("done_once_len16", W'(nd), W'(1));

        // Partial final beat: 3 live lanes.
        run_job(11, 0, 0, 100, -1, lat, nd);
        chk("len11_live", fin_pe_a[95:0], fin_in_a[95:0]);
        chk("len11_dead", fin_pe_a[W-1:96], '0);
        chk("lat_len11", W'(lat), W'(29));

        // Three-cycle stall before the only beat.
        run_job(8, 3, 3, 100, -1, lat, nd);
        chk("lat_len8_stall", W'(lat), W'(31));

        // Zero-length job.
        run_job(0, 0, 0, 100, -1, lat, nd);
        chk("lat_len0", W'(lat), W'(27));

        // start pulses while busy, including in the DONE cycle, are ignored.
        run_job(16, 0, 0, 100, 5, lat, nd);
        chk("done_once_restart", W'(nd), W'(1));
        run_job(16, 0, 0, 100, 29, lat, nd);
        chk("done_once_restart_done", W'(nd), W'(1));
        chk("lat_restart_done", W'(lat), W'(29));

        // Reset in the middle of STREAM.
        len = 16'd24;
        start = 1'b1;
        s0 = cyc;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        repeat (4) begin
            rand_data();
            tick();
        end
        rst = 1'b1;
        #1;
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_ready", W'(in_ready), W'(0));
        chk("rst_clr", W'(pe_clr), W'(1));
        chk("rst_pe_a", pe_a, '0);
        chk("rst_done", W'(done), W'(0));
        tick();
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("rst_job_started", W'(cyc - s0 > 5), W'(1));
        run_job(8, 0, 0, 100, -1, lat, nd);
        chk("lat_after_rst", W'(lat), W'(28));
        chk("done_once_after_rst", W'(nd), W'(1));

        // Random lengths with random valid gaps.
        for (int j = 0; j < 8; j++) begin
            run_job(int'($urandom_range(40)), 0, 0, 60, -1, lat, nd);
            chk("done_once_rand", W'(nd), W'(1));
        end

        // Maximum length: 8192 beats, final beat with 7 live lanes.
        run_job(65535, 0, 0, 100, -1, lat, nd);
        chk("lat_len65535", W'(lat), W'(1 + CLR + 8192 + DRAIN));
        chk("len65535_dead", fin_pe_a[W-1:224], '0);
        chk("len65535_live", fin_pe_a[223:0], fin_in_a[223:0]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fp32pe_feeder.md
FP32PE_FEEDER -- requirements
Module: fp32pe_feeder

Interface
REQ-001 SHALL have parameter LANES, default 8, number of FP32 lanes driven per cycle.
REQ-002 SHALL have parameter CLR_CYC, default 2, cycles pe_clr is held high per job.
REQ-003 SHALL have parameter DRAIN_CYC, default 24, cycles of zero operands after the last beat before done.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  job request; sampled only in IDLE.
REQ-007 len  input  16  dot-product length in elements, sampled with start.
REQ-008 in_valid  input  1  operand beat valid.
REQ-009 in_ready  output  1  operand beat accepted when in_valid and in_ready are both high.
REQ-010 in_a  input  32*LANES  A operands, lane k at bits [32k+31:32k].
REQ-011 in_b  input  32*LANES  B operands, same packing as in_a.
REQ-012 pe_a  output  32*LANES  registered A lanes to the PE.
REQ-013 pe_b  output  32*LANES  registered B lanes to the PE.
REQ-014 pe_clr  output  1  registered accumulator clear to the PE reset input.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse: the PE output now holds the finished dot product.

Function
REQ-017 SHALL implement FSM states IDLE, CLEAR, STREAM, DRAIN, DONE.
REQ-018 IDLE: start=1 latches len and beats_left = ceil(len/LANES); the FSM then enters CLEAR. A start outside IDLE SHALL be ignored.
REQ-019 CLEAR: pe_clr=1 and lanes drive +0.0 for exactly CLR_CYC cycles. The FSM then enters STREAM if len>0, else DRAIN.
REQ-020 STREAM: in_ready=1. On each accepted beat, pe_a/pe_b register in_a/in_b on the next edge and beats_left decrements.
REQ-021 STREAM with in_valid=0: pe_a/pe_b SHALL register 32'h0 in all lanes, because the PE accumulates every cycle.
REQ-022 Final beat: lanes with index >= (len mod LANES) SHALL be forced to 32'h0 on both A and B when len mod LANES != 0.
REQ-023 The accepted final beat moves the FSM to DRAIN. in_ready SHALL be low in every state except STREAM.
REQ-024 DRAIN: lanes drive 32'h0 for exactly DRAIN_CYC cycles, then the FSM enters DONE.
REQ-025 DONE: done=1 for exactly one cycle, then the FSM returns to IDLE. start in the DONE cycle SHALL be ignored.
REQ-026 A stream of N beats SHALL give start-to-done latency 1 + CLR_CYC + N + stall_cycles + DRAIN_CYC cycles.
REQ-027 The beat counter SHALL be 14 bits. len=65535 gives 8192 beats with a final mask of 7 live lanes.
REQ-028 Operands SHALL pass through bit-exact with no FP interpretation; only masking or zeroing applies.

Reset
REQ-029 Asserting rst at any time, including mid-stream, SHALL immediately force: state IDLE, pe_a/pe_b=0, pe_clr=1, in_ready=0, busy=0, done=0, counters=0.
REQ-030 pe_clr SHALL stay high from reset assertion until the first clock edge after rst deasserts; it is then 0 in IDLE.
REQ-031 A job interrupted by reset SHALL not resume; the next start restarts from CLEAR.

Structure
REQ-032 The FSM state encoding, LANES, and the FP32 zero constant SHALL live in the shared vector-ALU package.
REQ-033 The single sub-module SHALL be fp32_lane_mask: combinational, it zeroes lanes at index >= a live-count input.
REQ-034 The block SHALL contain no FP arithmetic; the PE instance stays external.

Verification
REQ-035 len=16 with two back-to-back beats: pe_clr high for cycles 1-2, beats in cycles 3-4, done at cycle 29 with CLR_CYC=2 and DRAIN_CYC=24.
REQ-036 len=11: the second beat's lanes 3-7 are 32'h0 on pe_a and pe_b, and lanes 0-2 equal the input.
REQ-037 len=8 with in_valid low for 3 cycles mid-job: zeros are driven during the stall and done is delayed by exactly 3 cycles.
REQ-038 len=0: CLEAR, then DRAIN, then done after 1+2+24 cycles, with in_ready never high.
REQ-039 rst asserted in the middle of STREAM: all outputs are at reset values immediately, and a new start with len=8 completes normally.
REQ-040 start pulsed while busy: it is ignored, and done pulses exactly once per accepted job.
